// File: rtl/quat_integrator_pkg.sv
// Shared Madgwick integration-stage types and default widths.
// Build switch MADGWICK_INTEG_ROUND_EN selects round-half-up instead of floor in quat_integ_mac.
package quat_integrator_pkg;

    localparam int Q_INT_WIDTH_DEF      = 2;
    localparam int Q_FRACT_WIDTH_DEF    = 14;
    localparam int QDOT_INT_WIDTH_DEF   = 4;
    localparam int QDOT_FRACT_WIDTH_DEF = 12;
    localparam int DT_WIDTH_DEF         = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } integ_state_t;

    // Right shift that brings q_dot*dt back onto the quaternion fraction grid.
    function automatic int integ_shift(input int qdot_fract, input int dt_w, input int q_fract);
        return qdot_fract + dt_w - q_fract;
    endfunction

endpackage

// File: rtl/quat_integ_mac.sv
// One lane of q + q_dot*dt: multiply, rescale, add, saturate (purely combinational).
// MADGWICK_INTEG_ROUND_EN defined: round half up; undefined: floor (plain arithmetic shift).
module quat_integ_mac
    import quat_integrator_pkg::*;
#(
    parameter int Q_INT_WIDTH      = Q_INT_WIDTH_DEF,
    parameter int Q_FRACT_WIDTH    = Q_FRACT_WIDTH_DEF,
    parameter int QDOT_INT_WIDTH   = QDOT_INT_WIDTH_DEF,
    parameter int QDOT_FRACT_WIDTH = QDOT_FRACT_WIDTH_DEF,
    parameter int DT_WIDTH         = DT_WIDTH_DEF,
    localparam int QW  = Q_INT_WIDTH + Q_FRACT_WIDTH,
    localparam int QDW = QDOT_INT_WIDTH + QDOT_FRACT_WIDTH
) (
    input  logic [QW-1:0]       q_lane,
    input  logic [QDW-1:0]      q_dot_lane,
    input  logic [DT_WIDTH-1:0] dt,
    output logic [QW-1:0]       q_next
);

    localparam int PW = QDW + DT_WIDTH + 1;
    localparam int SH = integ_shift(QDOT_FRACT_WIDTH, DT_WIDTH, Q_FRACT_WIDTH);

    localparam logic signed [PW-1:0] SAT_MAX = PW'((2 ** (QW - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

    generate
        if (SH < 1) begin : g_bad_shift
            $error("quat_integ_mac: fraction widths give a shift below 1");
        end
    endgenerate

    logic signed [QDW-1:0]    qd_s;
    logic signed [DT_WIDTH:0] dt_s;
    logic signed [QW-1:0]     q_s;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     biased;
    logic signed [PW-1:0]     inc;
    logic signed [PW-1:0]     sum;

`ifdef MADGWICK_INTEG_ROUND_EN
    localparam logic signed [PW-1:0] RND = PW'(1) <<< (SH - 1);
`endif

    always_comb begin
        qd_s = q_dot_lane;
        dt_s = {1'b0, dt};
        q_s  = q_lane;
        prod = PW'(qd_s) * PW'(dt_s);
`ifdef MADGWICK_INTEG_ROUND_EN
        biased = prod + RND;
`else
        biased = prod;
`endif
        inc = biased >>> SH;
        sum = PW'(q_s) + inc;
        if (sum > SAT_MAX) begin
            q_next = SAT_MAX[QW-1:0];
        end else if (sum < SAT_MIN) begin
            q_next = SAT_MIN[QW-1:0];
        end else begin
            q_next = sum[QW-1:0];
        end
    end

endmodule

// File: rtl/quat_integrator.sv
// Serial quaternion integrator q_next = q + q_dot*dt, one lane per cycle through a shared MAC.
// Rounding mode follows MADGWICK_INTEG_ROUND_EN (see quat_integ_mac); latency is the same either way.
module quat_integrator
    import quat_integrator_pkg::*;
#(
    parameter int Q_INT_WIDTH      = Q_INT_WIDTH_DEF,
    parameter int Q_FRACT_WIDTH    = Q_FRACT_WIDTH_DEF,
    parameter int QDOT_INT_WIDTH   = QDOT_INT_WIDTH_DEF,
    parameter int QDOT_FRACT_WIDTH = QDOT_FRACT_WIDTH_DEF,
    parameter int DT_WIDTH         = DT_WIDTH_DEF,
    localparam int QW  = Q_INT_WIDTH + Q_FRACT_WIDTH,
    localparam int QDW = QDOT_INT_WIDTH + QDOT_FRACT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                done,
    input  logic [DT_WIDTH-1:0] dt,
    input  logic [4*QW-1:0]     q_in,
    input  logic [4*QDW-1:0]    q_dot_in,
    output logic [4*QW-1:0]     q_out,
    output logic [1:0]          state_dbg
);

    // Handshake: start is a level held by the requester until it sees done=1.
    // done stays high (q_out stable) while start remains high, and falls on the
    // edge that observes start=0, returning to IDLE.

    integ_state_t         state;
    logic [1:0]           idx;
    logic [4*QW-1:0]      q_lat;
    logic [4*QDW-1:0]     q_dot_lat;
    logic [DT_WIDTH-1:0]  dt_lat;
    logic [QW-1:0]        q_lane;
    logic [QDW-1:0]       q_dot_lane;
    logic [QW-1:0]        mac_res;

    assign state_dbg = state;

    // Lane 0 is w, held in the most significant slice of the packed vectors.
    always_comb begin
        q_lane     = q_lat[(3 - int'(idx)) * QW +: QW];
        q_dot_lane = q_dot_lat[(3 - int'(idx)) * QDW +: QDW];
    end

    quat_integ_mac #(
        .Q_INT_WIDTH      (Q_INT_WIDTH),
        .Q_FRACT_WIDTH    (Q_FRACT_WIDTH),
        .QDOT_INT_WIDTH   (QDOT_INT_WIDTH),
        .QDOT_FRACT_WIDTH (QDOT_FRACT_WIDTH),
        .DT_WIDTH         (DT_WIDTH)
    ) u_mac (
        .q_lane     (q_lane),
        .q_dot_lane (q_dot_lane),
        .dt         (dt_lat),
        .q_next     (mac_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 2'd0;
            done      <= 1'b0;
            q_out     <= '0;
            q_lat     <= '0;
            q_dot_lat <= '0;
            dt_lat    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        q_lat     <= q_in;
                        q_dot_lat <= q_dot_in;
                        dt_lat    <= dt;
                        idx       <= 2'd0;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    q_out[(3 - int'(idx)) * QW +: QW] <= mac_res;
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // done is raised at least once even if start fell during CALC.
                    if (!done) begin
                        done <= 1'b1;
                    end else if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
